// File: rtl/pf_pkg.sv
// Shared types and helpers for the multi-channel pulse former.
package pf_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_BOTH = 2'd3
    } edge_mode_t;

    // Counter must hold PW-1; sized for PW so the PW=1 case still has one bit.
    function automatic int pf_cnt_w(input int pw);
        return $clog2(pw + 1);
    endfunction

endpackage

// File: rtl/pf_chan.sv
// One pulse-former channel: optional synchroniser, edge detect, pulse counter
// and sticky dropped-edge flag.
module pf_chan
    import pf_pkg::*;
#(
    parameter int PW     = 1,
    parameter int SYNC   = 2,
    parameter int RETRIG = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  edge_mode_t mode,
    input  logic       ovf_clr,
    output logic       q,
    output logic       ovf
);

    localparam int CW = pf_cnt_w(PW);
    localparam logic [CW-1:0] CNT_INIT = CW'(PW - 1);

    logic s;

    generate
        if (SYNC == 0) begin : g_nosync
            assign s = din;
        end else begin : g_sync
            logic [SYNC-1:0] sync_q;
            logic [SYNC-1:0] sync_d;

            always_comb sync_d = (sync_q << 1) | SYNC'(din);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) sync_q <= '0;
                else     sync_q <= sync_d;
            end

            assign s = sync_q[SYNC-1];
        end
    endgenerate

    logic          prev_q, prev_d;
    logic          armed_q, armed_d;
    logic          q_q, q_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise, fall, hit, ev;

    always_comb begin
        rise    = s & ~prev_q;
        fall    = ~s & prev_q;
        case (mode)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        // armed_q keeps a line that was already high through reset from firing.
        ev      = armed_q & hit;

        prev_d  = s;
        armed_d = 1'b1;
        q_d     = q_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_clr ? 1'b0 : ovf_q;

        if (!q_q) begin
            if (ev) begin
                q_d   = 1'b1;
                cnt_d = CNT_INIT;
            end
        end else if (ev && RETRIG != 0) begin
            cnt_d = CNT_INIT;
        end else begin
            // A dropped edge still lets the running pulse count down; set beats clear.
            if (ev) ovf_d = 1'b1;
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            else             q_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            q_q     <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
            q_q     <= q_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q   = q_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/pf_multi.sv
// Multi-channel pulse former: CH independent pf_chan instances, each with its
// own 2-bit edge-mode field.
module pf_multi
    import pf_pkg::*;
#(
    parameter int CH     = 4,
    parameter int PW     = 1,
    parameter int SYNC   = 2,
    parameter int RETRIG = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   in,
    input  logic [2*CH-1:0] mode,
    input  logic [CH-1:0]   ovf_clr,
    output logic [CH-1:0]   q,
    output logic [CH-1:0]   ovf
);

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            pf_chan #(
                .PW     (PW),
                .SYNC   (SYNC),
                .RETRIG (RETRIG)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .din     (in[i]),
                .mode    (edge_mode_t'(mode[2*i +: 2])),
                .ovf_clr (ovf_clr[i]),
                .q       (q[i]),
                .ovf     (ovf[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pf_multi.sv
// Bench for pf_multi: directed single-channel scenarios on several parameter
// sets plus a scoreboarded random run on two 4-channel instances.
module tb_pf_multi;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: PW=1 SYNC=0 RETRIG=0   B: PW=4 SYNC=2   C: PW=4 SYNC=0   D: PW=4 SYNC=0 RETRIG=1
    logic [0:0] inA = '0, inB = '0, inC = '0, inD = '0;
    logic [1:0] modeA = 2'd1, modeB = 2'd2, modeC = 2'd3, modeD = 2'd3;
    logic [0:0] clrA = '0, clrB = '0, clrC = '0, clrD = '0;
    logic [0:0] qA, qB, qC, qD, ovfA, ovfB, ovfC, ovfD;

    // E: CH=4 PW=3 SYNC=2 RETRIG=0   F: CH=4 PW=2 SYNC=0 RETRIG=1, shared stimulus
    logic [3:0] inR = '0, clrR = '0;
    logic [7:0] modeR = '0;
    logic [3:0] qE, ovfE, qF, ovfF;

    pf_multi #(.CH(1), .PW(1), .SYNC(0), .RETRIG(0)) dA (.clk(clk), .rst(rst), .in(inA), .mode(modeA), .ovf_clr(clrA), .q(qA), .ovf(ovfA));
    pf_multi #(.CH(1), .PW(4), .SYNC(2), .RETRIG(0)) dB (.clk(clk), .rst(rst), .in(inB), .mode(modeB), .ovf_clr(clrB), .q(qB), .ovf(ovfB));
    pf_multi #(.CH(1), .PW(4), .SYNC(0), .RETRIG(0)) dC (.clk(clk), .rst(rst), .in(inC), .mode(modeC), .ovf_clr(clrC), .q(qC), .ovf(ovfC));
    pf_multi #(.CH(1), .PW(4), .SYNC(0), .RETRIG(1)) dD (.clk(clk), .rst(rst), .in(inD), .mode(modeD), .ovf_clr(clrD), .q(qD), .ovf(ovfD));
    pf_multi #(.CH(4), .PW(3), .SYNC(2), .RETRIG(0)) dE (.clk(clk), .rst(rst), .in(inR), .mode(modeR), .ovf_clr(clrR), .q(qE), .ovf(ovfE));
    pf_multi #(.CH(4), .PW(2), .SYNC(0), .RETRIG(1)) dF (.clk(clk), .rst(rst), .in(inR), .mode(modeR), .ovf_clr(clrR), .q(qF), .ovf(ovfF));

    // Reference model state, indexed [dut][channel]
    bit m_sync [2][4][4];
    bit m_prev [2][4];
    bit m_armed[2][4];
    bit m_ovf  [2][4];
    int m_rem  [2][4];   // remaining high cycles of the pulse, q = (rem != 0)
    logic [7:0] sbE[$];
    logic [7:0] sbF[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 4; c++) begin
                for (int k = 0; k < 4; k++) m_sync[d][c][k] = 1'b0;
                m_prev[d][c]  = 1'b0;
                m_armed[d][c] = 1'b0;
                m_ovf[d][c]   = 1'b0;
                m_rem[d][c]   = 0;
            end
        sbE.delete();
        sbF.delete();
    endtask

    // Expected {ovf,q} after the coming clock edge, given the inputs about to be sampled.
    task automatic model_step(input int d, input int pw, input int sd, input bit rt,
                              input logic [3:0] inv, input logic [7:0] md, input logic [3:0] clr);
        logic [7:0] exp_v;
        bit s, r, f, ev, dropped;
        logic [1:0] m;
        for (int c = 0; c < 4; c++) begin
            if (sd == 0) s = inv[c];
            else         s = m_sync[d][c][sd-1];
            r  = s && !m_prev[d][c];
            f  = !s && m_prev[d][c];
            m  = md[2*c +: 2];
            ev = m_armed[d][c] && ((m == 2'd1 && r) || (m == 2'd2 && f) || (m == 2'd3 && (r || f)));
            dropped = 1'b0;
            if (ev && (m_rem[d][c] == 0 || rt)) begin
                m_rem[d][c] = pw;
            end else begin
                if (ev) dropped = 1'b1;
                if (m_rem[d][c] > 0) m_rem[d][c] = m_rem[d][c] - 1;
            end
            m_ovf[d][c] = (m_ovf[d][c] && !clr[c]) || dropped;
            for (int k = 3; k > 0; k--) m_sync[d][c][k] = m_sync[d][c][k-1];
            m_sync[d][c][0] = inv[c];
            m_prev[d][c]  = s;
            m_armed[d][c] = 1'b1;
            exp_v[c]     = (m_rem[d][c] != 0);
            exp_v[4 + c] = m_ovf[d][c];
        end
        if (d == 0) sbE.push_back(exp_v);
        else        sbF.push_back(exp_v);
    endtask

    task automatic test_reset();
        inA = '0; inB = '0; inC = '0; inD = '0; inR = '0; modeR = '0; clrR = '0;
        #2 rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({qA, qB, qC, qD, ovfA, ovfB, ovfC, ovfD} !== 8'h00) begin
            errors++;
            $display("FAIL reset_single got %b want 00000000", {qA, qB, qC, qD, ovfA, ovfB, ovfC, ovfD});
        end
        checks++;
        if ({qE, ovfE, qF, ovfF} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_multi got %h want 0000", {qE, ovfE, qF, ovfF});
        end
        rst = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_rise_pw1();
        logic [0:0] exp_q [12] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 12; i++) begin
            if (i == 0) inA = 1'b1;
            if (i == 8) inA = 1'b0;
            if (i == 10) inA = 1'b1;
            tick();
            checks++;
            if (qA !== exp_q[i] || ovfA !== 1'b0) begin
                errors++;
                $display("FAIL rise_pw1[%0d] got q=%b ovf=%b want q=%b ovf=0", i, qA, ovfA, exp_q[i]);
            end
        end
        inA = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            inA = ~inA;
            tick();
            checks++;
            if (qA !== inA || ovfA !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back[%0d] got q=%b ovf=%b want q=%b ovf=0", i, qA, ovfA, inA);
            end
        end
        inA = 1'b0;
        tick();
    endtask

    task automatic test_fall_sync();
        logic [0:0] exp_q [7] = '{0, 0, 1, 1, 1, 1, 0};
        inB = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (qB !== 1'b0) begin
                errors++;
                $display("FAIL fall_sync_rise[%0d] got q=%b want 0", i, qB);
            end
        end
        inB = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (qB !== exp_q[i]) begin
                errors++;
                $display("FAIL fall_sync[%0d] got q=%b want %b", i, qB, exp_q[i]);
            end
        end
    endtask

    task automatic test_ovf_drop();
        // step: drive inC/clrC, tick, expect {q, ovf}
        logic [0:0] in_s  [17] = '{1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
        logic [0:0] clr_s [17] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        logic [1:0] exp_s [17] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b00,
                                   2'b10, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00,
                                   2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 17; i++) begin
            inC  = in_s[i];
            clrC = clr_s[i];
            tick();
            checks++;
            if ({qC, ovfC} !== exp_s[i]) begin
                errors++;
                $display("FAIL ovf_drop[%0d] got q,ovf=%b want %b", i, {qC, ovfC}, exp_s[i]);
            end
        end
        clrC = 1'b1;
        inC  = 1'b0;
        tick();
        clrC = 1'b0;
    endtask

    task automatic test_retrig();
        logic [0:0] exp_q [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        inD = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 1) inD = 1'b0;
            checks++;
            if (qD !== exp_q[i] || ovfD !== 1'b0) begin
                errors++;
                $display("FAIL retrig[%0d] got q=%b ovf=%b want q=%b ovf=0", i, qD, ovfD, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_held_high();
        inA = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (qA !== 1'b0) begin
                errors++;
                $display("FAIL held_high[%0d] got q=%b want 0", i, qA);
            end
        end
        inA = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        inC = 1'b0;
        tick();
        inC = 1'b1;
        tick();
        checks++;
        if (qC !== 1'b1) begin
            errors++;
            $display("FAIL async_pre got q=%b want 1", qC);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (qC !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got q=%b want 0", qC);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (qC !== 1'b0) begin
                errors++;
                $display("FAIL async_after[%0d] got q=%b want 0", i, qC);
            end
        end
        inC = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] exp_v;
        bit tog;
        tog   = 1'b0;
        inR   = '0;
        clrR  = '0;
        modeR = 8'b11_10_01_11;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            tog = ~tog;
            if ((cyc / 500) % 2 == 0) inR = {4{tog}};
            else                      inR = 4'($urandom);
            if ($urandom_range(0, 15) == 0) modeR = 8'($urandom);
            clrR = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            model_step(0, 3, 2, 1'b0, inR, modeR, clrR);
            model_step(1, 2, 0, 1'b1, inR, modeR, clrR);
            tick();
            checks++;
            if (sbE.size() == 0) begin
                errors++;
                $display("FAIL random_E[%0d] scoreboard empty", cyc);
            end else begin
                exp_v = sbE.pop_front();
                if ({ovfE, qE} !== exp_v) begin
                    errors++;
                    $display("FAIL random_E[%0d] got ovf,q=%h want %h", cyc, {ovfE, qE}, exp_v);
                end
            end
            checks++;
            if (sbF.size() == 0) begin
                errors++;
                $display("FAIL random_F[%0d] scoreboard empty", cyc);
            end else begin
                exp_v = sbF.pop_front();
                if ({ovfF, qF} !== exp_v) begin
                    errors++;
                    $display("FAIL random_F[%0d] got ovf,q=%h want %h", cyc, {ovfF, qF}, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise_pw1();
        test_back_to_back();
        test_fall_sync();
        test_ovf_drop();
        test_retrig();
        test_reset_held_high();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pf_multi.md
Name: pf_multi

Overview:
- Parametrised multi-channel pulse former, the successor to the single-channel rising-edge former.
- Each channel optionally synchronises its input and detects a run-time selectable edge (rise, fall or both).
- On each detected edge the channel emits a pulse PW clk cycles wide, with optional retrigger and a sticky missed-edge flag.
- Used for strobe generation from asynchronous or slow control lines in front of FSMs and counters.

Parameters:
- CH, 4: number of independent channels, 1..32.
- PW, 1: output pulse width in clk cycles, 1..65535.
- SYNC, 2: input synchroniser depth in flops. 0 means the input is used directly (already in the clk domain).
- RETRIG, 0: 1 means an edge during a pulse restarts it; 0 means it is ignored and flagged.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in  input  CH  channel inputs.
- mode  input  2*CH  per-channel edge select, bits [2i+1:2i]: 0 off, 1 rise, 2 fall, 3 both.
- ovf_clr  input  CH  per-channel synchronous clear of ovf.
- q  output  CH  pulse outputs.
- ovf  output  CH  sticky flag: an edge was dropped because a pulse was already active.

Behaviour:
- Reset (async assert, sync release by the user): all synchroniser flops, prev, armed, cnt, q and ovf are 0.
- Synchroniser: an SYNC-stage shift of in[i] gives s[i]. With SYNC=0, s[i]=in[i].
- Sampling: prev[i]<=s[i] every cycle.
- armed: 0 after reset, 1 after the first clk edge. Events are suppressed while armed=0, so a line held high through reset produces no pulse.
- Events:
  - rise = s & ~prev
  - fall = ~s & prev
  - ev = armed & ((mode==1 & rise) | (mode==2 & fall) | (mode==3 & (rise|fall)))
- Latency: with SYNC=0, in high at edge k (and low at edge k-1) gives q=1 after edge k. In general q rises SYNC+1 edges after in first meets setup.
- Pulse: a counter cnt of width $clog2(PW+1) per channel.
  - ev with q=0 sets q<=1 and cnt<=PW-1.
  - While q=1 and cnt!=0, cnt decrements.
  - q=1 with cnt==0 sets q<=0 at the next edge.
  - q is high for exactly PW cycles.
- Edge during a pulse (ev with q=1):
  - RETRIG=1: cnt<=PW-1 and q stays 1, so the pulse ends PW cycles after the last edge. ovf is not set.
  - RETRIG=0: the edge is dropped and ovf[i]<=1. This includes an edge in the last high cycle.
- Minimum period for distinct pulses with RETRIG=0 is PW+1 cycles, since q goes low for at least one cycle.
- ovf: sticky until ovf_clr[i]=1. If set and clear occur in the same cycle, set wins.
- Mode change takes effect on the next event evaluation. Setting mode to 0 blocks new events but a running pulse completes.
- Both-edge mode with in toggling every cycle produces an event every cycle. It is handled per the rules above, with no special case.
- Channels are fully independent; there is no cross-channel interaction.
- rst asserted mid-pulse clears q and cnt immediately, without waiting for clk.
- PW=1, SYNC=0, RETRIG=0, mode=1 reproduces classic single-cycle rising-edge pulse behaviour.

Decomposition:
- Package pf_pkg:
  - typedef enum logic [1:0] edge_mode_t {EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH}
  - function for the counter width
- Sub-module pf_chan: one channel holding the synchroniser, prev, armed, cnt, q and ovf, with parameters PW, SYNC and RETRIG.
- pf_multi is a generate loop over CH instances of pf_chan plus mode slicing.

Test Plan:
1. PW=1, SYNC=0, mode=1: in rises at edge 10 and holds -> q=1 for edge 10 only; no further pulse until in falls and rises again.
2. PW=4, SYNC=2, mode=2: in falls before edge 20 -> q high for edges 22..25 and low at edge 26; rise ignored.
3. PW=4, RETRIG=0, mode=3: rise at edge 5, fall at edge 7 -> one pulse at edges 5..8, ovf=1 from edge 7. ovf_clr at edge 12 -> ovf=0. ovf_clr coincident with a dropped edge -> ovf stays 1.
4. PW=4, RETRIG=1, mode=3: edges at 5 and 7 -> q high at edges 5..10 continuously, ovf stays 0.
5. in held 1 through reset, rst released before edge 3, mode=1 -> no pulse. Pulse in progress and rst asserted mid-cycle -> q=0 immediately, without a clk edge.
6. CH=4 with a different mode per channel and a common toggling in -> each q matches an independent reference model for 10k random cycles, including mode changes mid-pulse.
